fft_pipe_ctrl: RTL and testbench

- Sequencing controller for the parallel-4 FFT datapath, a chain of complex-sample pipeline registers plus commutators and twiddle multipliers.
- Accepts a beat-valid input stream of P samples per beat and advances the datapath through a single enable.
- Drives commutator select and twiddle address from the input frame position, and tracks pipeline fill so output valid and frame markers align with data leaving the pipe.
- Handles stalls and an explicit end-of-stream drain (flush).

---
 rtl/fft_pipe_ctrl_pkg.sv | 17 +
 rtl/fft_pipe_ctrl_mod_cnt.sv | 39 +++
 rtl/fft_pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_fft_pipe_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pipe_ctrl_pkg.sv
// Shared definitions for the parallel-4 FFT pipeline controller:
// state encodings and default datapath geometry.
package fft_pipe_ctrl_pkg;

    // Controller states; code 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // Default FFT size, lanes per beat and datapath latency.
    localparam int DEF_N   = 128;
    localparam int DEF_P   = 4;
    localparam int DEF_LAT = 10;

endpackage

// File: rtl/fft_pipe_ctrl_mod_cnt.sv
// Modulo-MOD up-counter with enable and a wrap flag that is high on the
// enabled cycle in which the count rolls over from MOD-1 to 0.
module fft_pipe_ctrl_mod_cnt #(
    parameter int MOD = 32,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: advance on enable, roll over after the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_pipe_ctrl.sv
// Sequencing controller for the parallel-4 FFT datapath. Generates the
// single pipeline advance enable, the commutator/twiddle select, and
// output valid/frame markers aligned with beats leaving the pipe.
// Drains the pipe on request at the next input frame boundary.
module fft_pipe_ctrl
    import fft_pipe_ctrl_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int P   = DEF_P,
    parameter int LAT = DEF_LAT,
    localparam int F  = N / P,
    localparam int CW = $clog2(F),
    localparam int LW = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic          flush_i,
    output logic          in_ready_o,
    output logic          en_o,
    output logic [CW-1:0] sel_o,
    output logic          frame_start_o,
    output logic          out_valid_o,
    output logic          out_sof_o,
    output logic          out_eof_o,
    output logic          busy_o
);

    // A zero-latency datapath has no fill phase and cannot be sequenced.
    if (LAT < 1) begin : g_lat_check
        $error("fft_pipe_ctrl: LAT must be at least 1");
    end

    localparam logic [LW-1:0] LAT_L = LW'(LAT);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    state_e        state_q, state_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [LW-1:0] drain_q, drain_d;
    logic          flush_pend_q, flush_pend_d;

    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          in_wrap_unused;   // frame boundary is taken from in_cnt==0
    logic          out_wrap;
    logic          accept;
    logic          at_boundary;
    logic          flush_req;
    logic [LW-1:0] fill_inc;

    assign at_boundary = (in_cnt == '0);
    assign flush_req   = flush_pend_q || flush_i;
    assign fill_inc    = (fill_q == LAT_L) ? fill_q : fill_q + ONE_L;

    // Input beat position; drives commutator select and twiddle address.
    fft_pipe_ctrl_mod_cnt #(.MOD(F), .W(CW)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .cnt_o  (in_cnt),
        .wrap_o (in_wrap_unused)
    );

    // Output beat position, advanced only by valid output beats.
    fft_pipe_ctrl_mod_cnt #(.MOD(F), .W(CW)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (out_valid_o),
        .cnt_o  (out_cnt),
        .wrap_o (out_wrap)
    );

    // Output decode: purely combinational from registers and inputs.
    always_comb begin
        in_ready_o    = 1'b0;
        accept        = 1'b0;
        en_o          = 1'b0;
        frame_start_o = 1'b0;
        out_valid_o   = 1'b0;
        out_sof_o     = 1'b0;
        out_eof_o     = 1'b0;
        sel_o         = in_cnt;
        busy_o        = (state_q != ST_IDLE);

        // Input is refused on the boundary cycle that starts a drain.
        in_ready_o    = (state_q == ST_IDLE) ||
                        ((state_q == ST_RUN) && !(at_boundary && flush_req));
        accept        = in_valid_i && in_ready_o;
        en_o          = accept || (state_q == ST_FLUSH);
        frame_start_o = en_o && accept && at_boundary;
        // The pipe only presents real data once it has been advanced LAT times.
        out_valid_o   = en_o && (fill_q == LAT_L);
        out_sof_o     = out_valid_o && (out_cnt == '0);
        out_eof_o     = out_wrap;
    end

    // Next-state logic for the FSM, fill/drain counters and pending flush.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        drain_d      = drain_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = ST_RUN;
                    fill_d  = fill_inc;
                end
            end
            ST_RUN: begin
                if (at_boundary && flush_req) begin
                    state_d      = ST_FLUSH;
                    drain_d      = LAT_L;
                    flush_pend_d = 1'b0;
                end else begin
                    // A mid-frame request is held until the frame completes.
                    if (flush_i) begin
                        flush_pend_d = 1'b1;
                    end
                    if (accept) begin
                        fill_d = fill_inc;
                    end
                end
            end
            ST_FLUSH: begin
                fill_d  = fill_inc;
                drain_d = drain_q - ONE_L;
                if (drain_q == ONE_L) begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                fill_d       = '0;
                drain_d      = '0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            drain_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            drain_q      <= drain_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Directed testbench for fft_pipe_ctrl: a LAT=10 instance for the main
// scenarios and a LAT=40 instance for the partial-fill drain.
module tb_fft_pipe_ctrl;

    localparam int F = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready, en, frame_start, out_valid, out_sof, out_eof, busy;
    logic [4:0] sel;

    logic       rst40 = 1'b1;
    logic       in_valid40 = 1'b0;
    logic       flush40 = 1'b0;
    logic       in_ready40, en40, frame_start40, out_valid40, out_sof40, out_eof40, busy40;
    logic [4:0] sel40;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_pipe_ctrl #(.N(128), .P(4), .LAT(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid),
        .flush_i       (flush),
        .in_ready_o    (in_ready),
        .en_o          (en),
        .sel_o         (sel),
        .frame_start_o (frame_start),
        .out_valid_o   (out_valid),
        .out_sof_o     (out_sof),
        .out_eof_o     (out_eof),
        .busy_o        (busy)
    );

    fft_pipe_ctrl #(.N(128), .P(4), .LAT(40)) dut40 (
        .clk           (clk),
        .rst           (rst40),
        .in_valid_i    (in_valid40),
        .flush_i       (flush40),
        .in_ready_o    (in_ready40),
        .en_o          (en40),
        .sel_o         (sel40),
        .frame_start_o (frame_start40),
        .out_valid_o   (out_valid40),
        .out_sof_o     (out_sof40),
        .out_eof_o     (out_eof40),
        .busy_o        (busy40)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        logic [11:0] exp_rst;
        exp_rst = {1'b1, 11'b0};
        rst = 1'b1; rst40 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst40 = 1'b0;
        in_valid = 1'b1;
        repeat (3) next_cycle();
        in_valid = 1'b0;
        total++;
        if ({busy, sel} !== {1'b1, 5'd3}) begin
            bad++;
            $display("FAIL reset_pre: busy,sel got %b want %b", {busy, sel}, {1'b1, 5'd3});
        end
        #2;
        rst = 1'b1;
        #1;
        obs = {in_ready, en, sel, frame_start, out_valid, out_sof, out_eof, busy};
        total++;
        if (obs !== exp_rst) begin
            bad++;
            $display("FAIL reset_async: outputs got %b want %b", obs, exp_rst);
        end
        next_cycle();
        obs = {in_ready, en, sel, frame_start, out_valid, out_sof, out_eof, busy};
        total++;
        if (obs !== exp_rst) begin
            bad++;
            $display("FAIL reset_hold: outputs got %b want %b", obs, exp_rst);
        end
        obs = {in_ready40, en40, sel40, frame_start40, out_valid40, out_sof40, out_eof40, busy40};
        total++;
        if (obs !== exp_rst) begin
            bad++;
            $display("FAIL reset_lat40: outputs got %b want %b", obs, exp_rst);
        end
        rst = 1'b0;
        next_cycle();
        $display("test_reset: done");
    endtask

    task automatic test_frame_flush();
        int ecyc = 0, beats = 0, outs = 0, first_out = -1, sof_cnt = 0, fs_cnt = 0;
        int eof_cnt = 0, eof_at = -1, idle_at = -1, ready_bad = 0, sel_bad = 0;
        logic sof_first = 1'b0;
        bit started = 0;
        for (int c = 0; c < 100 && idle_at < 0; c++) begin
            in_valid = (beats < F);
            flush    = (beats == 4);
            @(negedge clk);
            if (en) ecyc++;
            if (out_valid) begin
                outs++;
                if (first_out < 0) begin
                    first_out = ecyc;
                    sof_first = out_sof;
                end
                if (out_sof) sof_cnt++;
                if (out_eof) begin
                    eof_cnt++;
                    eof_at = outs;
                end
            end
            if (frame_start) fs_cnt++;
            if (beats == F && busy && in_ready) ready_bad++;
            if (in_valid && in_ready) begin
                if (sel !== 5'(beats % F)) sel_bad++;
                beats++;
            end
            if (busy) started = 1;
            else if (started) idle_at = ecyc;
            next_cycle();
        end
        in_valid = 1'b0; flush = 1'b0;
        total++; if (first_out !== 11) begin bad++; $display("FAIL frame_first_out: got %0d want 11", first_out); end
        total++; if (sof_first !== 1'b1) begin bad++; $display("FAIL frame_sof_first: got %b want 1", sof_first); end
        total++; if (sof_cnt !== 1) begin bad++; $display("FAIL frame_sof_count: got %0d want 1", sof_cnt); end
        total++; if (outs !== 32) begin bad++; $display("FAIL frame_outs: got %0d want 32", outs); end
        total++; if (eof_cnt !== 1 || eof_at !== 32) begin bad++; $display("FAIL frame_eof: got count %0d at %0d want 1 at 32", eof_cnt, eof_at); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL frame_ready_drain: got %0d ready cycles want 0", ready_bad); end
        total++; if (sel_bad !== 0) begin bad++; $display("FAIL frame_sel: got %0d wrong selects want 0", sel_bad); end
        total++; if (idle_at !== 42) begin bad++; $display("FAIL frame_idle_at: got %0d want 42", idle_at); end
        $display("test_frame_flush: outs=%0d first_out=%0d idle_at=%0d", outs, first_out, idle_at);
    endtask

    task automatic test_stall();
        int ecyc = 0, beats = 0, outs = 0, gap = 0, gap_bad = 0, cont_bad = 0, idle_at = -1;
        bit started = 0;
        for (int c = 0; c < 100 && idle_at < 0; c++) begin
            in_valid = (beats < F) && !(beats == 7 && gap < 3);
            flush    = (beats == 20);
            @(negedge clk);
            if (en) ecyc++;
            if (beats == 7 && !in_valid) begin
                gap++;
                if ({en, sel, out_valid} !== {1'b0, 5'd7, 1'b0}) gap_bad++;
            end
            if (out_valid) begin
                outs++;
                if (ecyc != 10 + outs) cont_bad++;
            end
            if (in_valid && in_ready) beats++;
            if (busy) started = 1;
            else if (started) idle_at = ecyc;
            next_cycle();
        end
        in_valid = 1'b0; flush = 1'b0;
        total++; if (gap !== 3) begin bad++; $display("FAIL stall_gap: got %0d want 3", gap); end
        total++; if (gap_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d bad gap cycles want 0", gap_bad); end
        total++; if (outs !== 32) begin bad++; $display("FAIL stall_outs: got %0d want 32", outs); end
        total++; if (cont_bad !== 0) begin bad++; $display("FAIL stall_contig: got %0d misplaced outputs want 0", cont_bad); end
        total++; if (idle_at !== 42) begin bad++; $display("FAIL stall_idle_at: got %0d want 42", idle_at); end
        $display("test_stall: gap=%0d outs=%0d idle_at=%0d", gap, outs, idle_at);
    endtask

    task automatic test_two_frames();
        int ecyc = 0, beats = 0, outs = 0, fs_cnt = 0, sof_cnt = 0, eof_cnt = 0;
        int fl_cyc = 0, idle_at = -1;
        bit flush_sent = 0, after_pending = 0, started = 0;
        logic [1:0] at_flush = 2'bxx;
        logic [2:0] after_flush = 3'bxxx;
        for (int c = 0; c < 150 && idle_at < 0; c++) begin
            in_valid = (beats < 2 * F) || !flush_sent || (fl_cyc < 5);
            flush    = (beats == 2 * F) && !flush_sent;
            @(negedge clk);
            if (after_pending) begin
                after_flush   = {busy, en, in_ready};
                after_pending = 0;
            end
            if (flush) begin
                at_flush      = {in_ready, en};
                flush_sent    = 1;
                after_pending = 1;
            end else if (flush_sent && en) begin
                fl_cyc++;
            end
            if (en) ecyc++;
            if (out_valid) outs++;
            if (out_valid && out_sof) sof_cnt++;
            if (out_valid && out_eof) eof_cnt++;
            if (frame_start) fs_cnt++;
            if (in_valid && in_ready) beats++;
            if (busy) started = 1;
            else if (started) idle_at = ecyc;
            next_cycle();
        end
        in_valid = 1'b0; flush = 1'b0;
        total++; if (at_flush !== 2'b00) begin bad++; $display("FAIL two_flush_same_cycle: ready,en got %b want 00", at_flush); end
        total++; if (after_flush !== 3'b110) begin bad++; $display("FAIL two_flush_entered: busy,en,ready got %b want 110", after_flush); end
        total++; if (fs_cnt !== 2) begin bad++; $display("FAIL two_frame_start: got %0d want 2", fs_cnt); end
        total++; if (sof_cnt !== 2) begin bad++; $display("FAIL two_sof: got %0d want 2", sof_cnt); end
        total++; if (eof_cnt !== 2) begin bad++; $display("FAIL two_eof: got %0d want 2", eof_cnt); end
        total++; if (outs !== 64) begin bad++; $display("FAIL two_outs: got %0d want 64", outs); end
        total++; if (beats !== 64) begin bad++; $display("FAIL two_accepted: got %0d want 64", beats); end
        total++; if (idle_at !== 74) begin bad++; $display("FAIL two_idle_at: got %0d want 74", idle_at); end
        $display("test_two_frames: beats=%0d outs=%0d idle_at=%0d", beats, outs, idle_at);
    endtask

    task automatic test_reset_flush();
        int ecyc = 0, beats = 0, outs = 0, fl_cyc = 0, post_bad = 0, first_out = -1;
        logic sof_first = 1'b0;
        logic [11:0] obs;
        bit done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            in_valid = (beats < F);
            flush    = (beats == 9);
            @(negedge clk);
            if (en) ecyc++;
            if (out_valid) outs++;
            if (beats == F && en) fl_cyc++;
            if (in_valid && in_ready) beats++;
            if (fl_cyc == 7) done = 1;
            else next_cycle();
        end
        in_valid = 1'b0; flush = 1'b0;
        total++; if (outs !== 29) begin bad++; $display("FAIL rstfl_outs_before: got %0d want 29", outs); end
        #1;
        rst = 1'b1;
        #1;
        obs = {in_ready, en, sel, frame_start, out_valid, out_sof, out_eof, busy};
        total++;
        if (obs !== {1'b1, 11'b0}) begin
            bad++;
            $display("FAIL rstfl_async: outputs got %b want %b", obs, {1'b1, 11'b0});
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) post_bad++;
            next_cycle();
        end
        total++; if (post_bad !== 0) begin bad++; $display("FAIL rstfl_quiet: got %0d active cycles want 0", post_bad); end
        ecyc = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (en) ecyc++;
            if (out_valid && first_out < 0) begin
                first_out = ecyc;
                sof_first = out_sof;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        total++; if (first_out !== 11) begin bad++; $display("FAIL rstfl_restart_first: got %0d want 11", first_out); end
        total++; if (sof_first !== 1'b1) begin bad++; $display("FAIL rstfl_restart_sof: got %b want 1", sof_first); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        $display("test_reset_flush: outs_before=%0d restart_first=%0d", outs, first_out);
    endtask

    task automatic test_partial_fill();
        int ecyc = 0, beats = 0, outs = 0, during_in = 0, first_dc = -1, last_dc = -1, idle_at = -1;
        bit started = 0;
        for (int c = 0; c < 150 && idle_at < 0; c++) begin
            in_valid40 = (beats < F);
            flush40    = (beats == F - 1);
            @(negedge clk);
            if (en40) ecyc++;
            if (out_valid40) begin
                outs++;
                if (ecyc <= F) during_in++;
                else begin
                    if (first_dc < 0) first_dc = ecyc - F;
                    last_dc = ecyc - F;
                end
            end
            if (in_valid40 && in_ready40) beats++;
            if (busy40) started = 1;
            else if (started) idle_at = ecyc;
            next_cycle();
        end
        in_valid40 = 1'b0; flush40 = 1'b0;
        total++; if (during_in !== 0) begin bad++; $display("FAIL partial_early: got %0d outputs during input want 0", during_in); end
        total++; if (outs !== 32) begin bad++; $display("FAIL partial_outs: got %0d want 32", outs); end
        total++; if (first_dc !== 9) begin bad++; $display("FAIL partial_first_drain: got %0d want 9", first_dc); end
        total++; if (last_dc !== 40) begin bad++; $display("FAIL partial_last_drain: got %0d want 40", last_dc); end
        total++; if (idle_at !== 72) begin bad++; $display("FAIL partial_idle_at: got %0d want 72", idle_at); end
        $display("test_partial_fill: outs=%0d drain_first=%0d drain_last=%0d", outs, first_dc, last_dc);
    endtask

    initial begin
        test_reset();
        test_frame_flush();
        test_stall();
        test_two_frames();
        test_reset_flush();
        test_partial_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
